// File: rtl/simplez_pkg.sv
// Shared defaults and FSM encoding for the two-port memory arbiter.
// Owner encoding: 0 = port A (CPU), 1 = port B (loader/debug).
package simplez_pkg;

   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned DATA_W_DEF = 12;

   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between ports A and B.
// MEM_ARB_RR_EN defined: ties go to the pointer; undefined: B always wins ties.
module mem_arb_pick
   import simplez_pkg::*;
(
   input  logic a_req_i,
   input  logic b_req_i,
   input  logic ptr_i,
   output logic win_c_o
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      win_c_o = OWN_A;
      if (a_req_i && b_req_i) begin
         win_c_o = ptr_i;
      end else if (b_req_i) begin
         win_c_o = OWN_B;
      end
   end
`else
   // Fixed priority only looks at B; the other inputs are kept for a uniform interface.
   logic unused_in;
   assign unused_in = a_req_i ^ ptr_i;

   always_comb begin
      win_c_o = OWN_A;
      if (b_req_i) begin
         win_c_o = OWN_B;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: IDLE -> ACCESS -> DONE per access.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port B.
module mem_arbiter
   import simplez_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,

   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy
);

   state_e              state_q, state_d;
   logic                own_q, own_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_wr_q, mem_wr_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
   logic                busy_q, busy_d;
   logic                ptr_c;
   logic                win_c;

`ifdef MEM_ARB_RR_EN
   logic                ptr_q, ptr_d;
   assign ptr_c = ptr_q;
`else
   assign ptr_c = OWN_A;
`endif

   mem_arb_pick u_pick (
      .a_req_i (a_req),
      .b_req_i (b_req),
      .ptr_i   (ptr_c),
      .win_c_o (win_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (a_req || b_req) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; everything leaves the block through a flop
   always_comb begin
      own_d       = own_q;
      we_d        = we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_d    = 1'b0;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      busy_d      = (state_d != IDLE);
`ifdef MEM_ARB_RR_EN
      ptr_d       = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               own_d       = win_c;
               we_d        = (win_c == OWN_B) ? b_we    : a_we;
               mem_addr_d  = (win_c == OWN_B) ? b_addr  : a_addr;
               mem_wdata_d = (win_c == OWN_B) ? b_wdata : a_wdata;
               // mem_wr rises with the ACCESS state and falls on the next edge
               mem_wr_d    = we_d;
`ifdef MEM_ARB_RR_EN
               ptr_d       = ~win_c;
`endif
            end
         end
         ACCESS: begin
            mem_wr_d = 1'b0;
         end
         DONE: begin
            if (own_q == OWN_B) begin
               b_ack_d = 1'b1;
               if (!we_q) b_rdata_d = mem_rdata;
            end else begin
               a_ack_d = 1'b1;
               if (!we_q) a_rdata_d = mem_rdata;
            end
         end
         default: begin
            mem_wr_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         own_q       <= OWN_A;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_q    <= 1'b0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         ptr_q       <= OWN_A;
`endif
      end else begin
         own_q       <= own_d;
         we_q        <= we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants and data,
// a negedge monitor compares acks, read data and memory-side strobes against it.
module tb_mem_arbiter;

   localparam int unsigned AW    = 9;
   localparam int unsigned DW    = 12;
   localparam int unsigned DEPTH = 512;

   logic          clk;
   logic          rst;
   logic          a_req, a_we, a_ack;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_rdata;
   logic          b_req, b_we, b_ack;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory, sampled on the falling edge
   logic [DW-1:0] mem [DEPTH];
   always @(negedge clk) begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic          port;
      logic [DW-1:0] rdata;
      int            due;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] sh_mem [DEPTH];
   logic [DW-1:0] last_rd [2];
   logic [DW-1:0] shown [2];
   int            cnt   = 0;     // cycles remaining until the arbiter is free again
   logic          m_ptr = 1'b0;  // port favoured on a tie (round-robin only)
   logic          m_w;
   logic          acc_we = 1'b0;
   logic [AW-1:0] acc_addr = '0;
   logic [DW-1:0] acc_wdata = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         cnt        = 0;
         m_ptr      = 1'b0;
         exp_q.delete();
         last_rd[0] = '0;
         last_rd[1] = '0;
         shown[0]   = '0;
         shown[1]   = '0;
      end else if (cnt > 0) begin
         cnt--;
      end else if (a_req || b_req) begin
`ifdef MEM_ARB_RR_EN
         m_w   = (a_req && b_req) ? m_ptr : b_req;
         m_ptr = ~m_w;
`else
         m_w   = b_req;
`endif
         acc_we    = m_w ? b_we    : a_we;
         acc_addr  = m_w ? b_addr  : a_addr;
         acc_wdata = m_w ? b_wdata : a_wdata;
         if (acc_we) sh_mem[acc_addr] = acc_wdata;
         else        last_rd[m_w]     = sh_mem[acc_addr];
         exp_q.push_back('{port: m_w, rdata: last_rd[m_w], due: cyc + 2});
         cnt = 2;
      end
   end

   // ---------------- monitor ----------------
   exp_t mon_e;
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(cnt > 0));
         check("mem_wr", 32'(mem_wr), 32'(cnt == 2 && acc_we));
         if (cnt == 2) begin
            check("mem_addr", 32'(mem_addr), 32'(acc_addr));
            if (acc_we) check("mem_wdata", 32'(mem_wdata), 32'(acc_wdata));
         end
         check("ack_onehot", 32'(a_ack & b_ack), 32'd0);
         if (a_ack || b_ack) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", 32'({a_ack, b_ack}), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("ack_port", 32'(b_ack), 32'(mon_e.port));
               check("ack_cycle", 32'(cyc), 32'(mon_e.due));
               check("ack_rdata", 32'(b_ack ? b_rdata : a_rdata), 32'(mon_e.rdata));
               shown[mon_e.port] = mon_e.rdata;
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check("missing_ack", 32'(cyc), 32'(mon_e.due + 1000));
            shown[mon_e.port] = mon_e.rdata;
         end
         check("a_rdata_hold", 32'(a_rdata), 32'(shown[0]));
         check("b_rdata_hold", 32'(b_rdata), 32'(shown[1]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_port(input bit p, input logic r, input logic we,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
      if (p) begin b_req = r; b_we = we; b_addr = ad; b_wdata = wd; end
      else   begin a_req = r; a_we = we; a_addr = ad; a_wdata = wd; end
   endtask

   task automatic set_rand(input bit p, input logic r, input int amax);
      set_port(p, r, 1'($urandom_range(1, 0)), AW'($urandom_range(amax, 0)), DW'($urandom));
   endtask

   // Waits for the port's ack; optionally scrambles the request fields while waiting
   task automatic wait_ack(input bit p, input bit scramble, input int amax);
      int t;
      t = 0;
      forever begin
         @(posedge clk); #1;
         if (p ? b_ack : a_ack) break;
         t++;
         if (t > 40) begin
            check(p ? "b_ack_timeout" : "a_ack_timeout", 32'd0, 32'd1);
            break;
         end
         if (scramble && $urandom_range(1, 0) == 1) set_rand(p, 1'b1, amax);
      end
   endtask

   task automatic run_port(input bit p, input int n, input int gap_max, input int amax);
      int g;
      for (int k = 0; k < n; k++) begin
         g = int'($urandom_range(gap_max, 0));
         if (g > 0) begin
            set_rand(p, 1'b0, amax);
            repeat (g) @(posedge clk);
            #1;
         end
         set_rand(p, 1'b1, amax);
         wait_ack(p, 1'b1, amax);
      end
      set_port(p, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem[i]    = DW'(i);
         sh_mem[i] = DW'(i);
      end
      last_rd[0] = '0; last_rd[1] = '0;
      shown[0]   = '0; shown[1]   = '0;
      rst = 1'b1;
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_acks", 32'({a_ack, b_ack}), 32'd0);

      // Single read from A
      rst = 1'b0;
      set_port(1'b0, 1'b1, 1'b0, AW'(3), '0);
      wait_ack(1'b0, 1'b0, 0);
      check("a_read_3", 32'(a_rdata), 32'o0003);
      set_port(1'b0, 1'b0, 1'b0, '0, '0);

      // Write from B, then read it back through A
      set_port(1'b1, 1'b1, 1'b1, AW'(8), DW'(12'o7000));
      wait_ack(1'b1, 1'b0, 0);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      set_port(1'b0, 1'b1, 1'b0, AW'(8), '0);
      wait_ack(1'b0, 1'b0, 0);
      check("a_read_back", 32'(a_rdata), 32'o7000);
      set_port(1'b0, 1'b0, 1'b0, '0, '0);

      // Both requesting straight out of reset
      rst = 1'b1;
      set_port(1'b0, 1'b1, 1'b0, AW'(2), '0);
      set_port(1'b1, 1'b1, 1'b0, AW'(4), '0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      fork
         begin wait_ack(1'b0, 1'b0, 0); set_port(1'b0, 1'b0, 1'b0, '0, '0); end
         begin wait_ack(1'b1, 1'b0, 0); set_port(1'b1, 1'b0, 1'b0, '0, '0); end
      join

      // Both ports held requesting for 12 cycles
      set_port(1'b0, 1'b1, 1'b0, AW'(6), '0);
      set_port(1'b1, 1'b1, 1'b0, AW'(7), '0);
      repeat (12) @(posedge clk);
      #1;
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      set_port(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (6) @(posedge clk);
      #1;

      // Reset landing on the ACCESS cycle of a write to address 5
      set_port(1'b0, 1'b1, 1'b1, AW'(5), DW'(12'o1234));
      for (int t = 0; t < 10 && cnt != 2; t++) begin
         @(posedge clk); #1;
      end
      check("reached_access", 32'(cnt), 32'd2);
      rst = 1'b1;
      set_port(1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_access_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_access_busy", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;

      // Randomised traffic on both ports over a small address window
      fork
         run_port(1'b0, 30, 3, 15);
         run_port(1'b1, 30, 3, 15);
      join
      repeat (8) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 9, memory address width; DATA_W, 12, memory word width.
REQ-002 SHALL have ports, one clock, synchronous active-high reset: clk  in  1  clock, all logic on posedge; rst  in  1  synchronous reset, active high.
REQ-003 a_req  in  1  CPU port request, held until a_ack; a_we  in  1  1=write 0=read; a_addr  in  ADDR_W  address; a_wdata  in  DATA_W  write data.
REQ-004 a_ack  out  1  one-cycle completion pulse; a_rdata  out  DATA_W  read data, valid while a_ack=1.
REQ-005 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: loader/debug port, identical widths and meaning to port A.
REQ-006 mem_addr  out  ADDR_W  to memory addr; mem_wr  out  1  to memory wr; mem_wdata  out  DATA_W  to memory data_in; mem_rdata  in  DATA_W  from memory data_out (memory samples on negedge clk).
REQ-007 busy  out  1  high in any state other than IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other transitions except reset.
REQ-009 IDLE: if any req=1 at posedge, SHALL latch winner (owner), its we/addr/wdata, and go ACCESS; else stay IDLE.
REQ-010 ACCESS: mem_addr/mem_wdata SHALL hold latched values; mem_wr SHALL equal latched we for this one cycle only; next state DONE unconditionally.
REQ-011 DONE: SHALL capture mem_rdata into owner's rdata register and pulse owner's ack for exactly one cycle; other port's ack SHALL stay 0; next state IDLE.
REQ-012 Latency: req sampled at edge T -> ack high in cycle starting at edge T+2; one access per 3 cycles max.
REQ-013 mem_wr SHALL be 0 in IDLE and DONE; never asserted for a read.
REQ-014 Requester inputs changing while not IDLE SHALL be ignored (latched copies used).
REQ-015 Writes: ack SHALL pulse in DONE; rdata register for that port SHALL hold its previous value.
REQ-016 x_rdata SHALL hold last read value between accesses.
REQ-017 Requester keeping req high after ack SHALL be treated as a new request in IDLE.
REQ-018 Simultaneous a_req and b_req in IDLE: winner per REQ-022; loser stays pending, served next IDLE.

Reset
REQ-019 rst=1 at posedge SHALL force IDLE, acks 0, mem_wr 0, mem_addr 0, mem_wdata 0, rdata registers 0, busy 0, priority pointer to A.
REQ-020 Reset during ACCESS SHALL deassert mem_wr at that edge and drop the transaction with no ack.
REQ-021 rst SHALL override all other inputs in the same cycle.

Configuration
REQ-022 Macro MEM_ARB_RR_EN: defined -> round-robin; pointer toggles to the non-winner after each granted access; tie goes to pointer. Undefined -> fixed priority, port B always wins ties; no pointer flop.

Structure
REQ-023 Shared package simplez_pkg SHALL hold ADDR_W/DATA_W defaults and FSM state enum (IDLE, ACCESS, DONE).
REQ-024 Arbitration decision SHALL be sub-module mem_arb_pick (inputs: both reqs, pointer; output: winner), combinational, instantiated once.

Verification
REQ-025 Reset then a_req read addr 0o003, mem[3]=0o0003 -> a_ack at T+2, a_rdata=0o0003, b_ack=0.
REQ-026 b_req write addr 0o010 data 0o7000 -> mem_wr=1 exactly one cycle with mem_addr=0o010, b_ack at T+2; subsequent a read of 0o010 returns 0o7000.
REQ-027 a_req and b_req both high from reset, reads of 2 and 4 -> with MEM_ARB_RR_EN: A first (0o0002), then B (0o0004); without: B first, then A.
REQ-028 Both ports held requesting for 12 cycles with MEM_ARB_RR_EN -> acks alternate A,B,A,B, one every 3 cycles; without -> only B acked.
REQ-029 rst asserted in ACCESS of a write to addr 5 -> no ack, busy=0 next cycle, mem_wr=0 after reset edge.
